// File: rtl/shift_unit_pipe_if.sv
// rtl/shift_unit_pipe_if.sv - operation/result handshake bundle for shift_unit_pipe
interface shift_unit_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_data;
  logic [5:0]       in_shamt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output flush, in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_illegal
  );
endinterface

// File: rtl/shift_unit_pipe.sv
// rtl/shift_unit_pipe.sv - pipelined SLL/SRL/SRA and word-form barrel shifter
module shift_unit_pipe #(
  parameter int XLEN        = 64,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input logic              clk,
  input logic              rst_n,
  shift_unit_pipe_if.slave bus
);
  localparam int LVLS      = $clog2(XLEN);
  localparam int PER_STAGE = (LVLS + PIPE_STAGES - 1) / PIPE_STAGES;
  localparam bit HAS_WORD  = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [LVLS-1:0]  shamt;
    logic [2:0]       op;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t                 in_stage;
  stage_t                 st [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] vld;
  logic [PIPE_STAGES:0]   rdy;
  logic                   accept;
  logic                   unused_bits;

  assign rdy[PIPE_STAGES] = bus.out_ready;
  assign bus.in_ready     = rdy[0] & ~bus.flush;
  assign accept           = bus.in_valid & bus.in_ready;

  // Word ops pre-extend the low half so the shared 64-bit right shift fills correctly.
  always_comb begin
    in_stage         = '0;
    in_stage.op      = bus.in_op;
    in_stage.tag     = bus.in_tag;
    in_stage.illegal = (bus.in_op[1:0] == 2'b11);
    in_stage.shamt   = bus.in_shamt[LVLS-1:0];
    in_stage.data    = bus.in_data;
    if (in_stage.illegal) begin
      in_stage.shamt = '0;
    end else if (HAS_WORD && bus.in_op[2]) begin
      in_stage.shamt[LVLS-1] = 1'b0;
      if (bus.in_op[1])
        in_stage.data = XLEN'($signed(bus.in_data[31:0]));
      else
        in_stage.data = XLEN'(bus.in_data[31:0]);
    end
  end

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    stage_t src;
    stage_t res;
    stage_t r;
    logic   vin;
    logic   v;

    if (k == 0) begin : g_head
      assign src = in_stage;
      assign vin = accept;
    end else begin : g_body
      assign src = st[k-1];
      assign vin = vld[k-1];
    end

    // This stage owns mux levels [k*PER_STAGE, (k+1)*PER_STAGE), largest amount first.
    always_comb begin
      res = src;
      for (int j = k * PER_STAGE; j < LVLS && j < (k + 1) * PER_STAGE; j++) begin
        if (src.shamt[LVLS-1-j]) begin
          if (src.op[1:0] == 2'b00)
            res.data = res.data << (1 << (LVLS - 1 - j));
          else if (src.op[1])
            res.data = XLEN'($signed(res.data) >>> (1 << (LVLS - 1 - j)));
          else
            res.data = res.data >> (1 << (LVLS - 1 - j));
        end
      end
      if (k == PIPE_STAGES - 1 && HAS_WORD && src.op[2] && !src.illegal)
        res.data = XLEN'($signed(res.data[31:0]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= 1'b0;
        r <= '0;
      end else if (bus.flush) begin
        v <= 1'b0;
      end else if (rdy[k]) begin
        v <= vin;
        if (vin)
          r <= res;
      end
    end

    assign vld[k] = v;
    assign st[k]  = r;
    assign rdy[k] = ~v | rdy[k+1];
  end

  assign bus.out_valid   = vld[PIPE_STAGES-1];
  assign bus.out_data    = st[PIPE_STAGES-1].data;
  assign bus.out_tag     = st[PIPE_STAGES-1].tag;
  assign bus.out_illegal = st[PIPE_STAGES-1].illegal;

  assign unused_bits = ^{st[PIPE_STAGES-1].shamt, st[PIPE_STAGES-1].op, bus.in_shamt};
endmodule
